// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- oversampling UART receiver with optional parity.
//
// Receives one frame: a start bit, DATA_WIDTH data bits (LSB first), an
// optional parity bit and one stop bit. Each bit lasts Prescale clocks and is
// decided by a 2-of-3 majority vote around its centre.
//
// Ports
//   CLK        in   system clock, all state updates on the rising edge
//   RST        in   synchronous active-high reset
//   RX_IN      in   serial line, idle high, already synchronised
//   PAR_EN     in   1 = frame carries a parity bit
//   PAR_TYP    in   0 = even parity, 1 = odd parity
//   Prescale   in   clocks per bit (8, 16 or 32; anything else acts as 8)
//   P_DATA     out  last correctly received word
//   data_valid out  one-cycle pulse, P_DATA was just loaded
//   par_err    out  one-cycle pulse, parity mismatch in the frame just ended
//   stp_err    out  one-cycle pulse, stop bit sampled low
//   busy       out  high whenever a frame is in progress
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int             BCW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                state_q;
    logic [5:0]            edge_cnt_q;
    logic [BCW-1:0]        bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [5:0]            pre_q;       // prescale latched for the current frame
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  mismatch_q;  // parity mismatch seen in this frame
    logic [1:0]            samp_q;      // first two of the three centre samples
    logic                  bit_q;       // majority-voted value of the current bit

    logic [5:0]            pre_d;
    logic [5:0]            half_d;
    logic                  last_edge_d;
    logic                  maj_d;
    logic [DATA_WIDTH-1:0] shift_d;

    // XOR reduction of the received word (1 when it holds an odd number of ones)
    function automatic logic word_parity(input logic [DATA_WIDTH-1:0] word);
        return ^word;
    endfunction

    // Derived helpers: sanitised prescale, bit centre, bit end, vote, next shift value
    always_comb begin
        pre_d = 6'd8;
        if ((Prescale == 6'd16) || (Prescale == 6'd32)) begin
            pre_d = Prescale;
        end else begin
            pre_d = 6'd8;
        end
        half_d      = {1'b0, pre_q[5:1]};
        last_edge_d = (edge_cnt_q == (pre_q - 6'd1));
        // Third sample comes straight from the line on the cycle it is taken
        maj_d       = (samp_q[0] & samp_q[1]) | (samp_q[0] & RX_IN) | (samp_q[1] & RX_IN);
        // LSB-first reception: new bit enters at the top and moves down
        shift_d                 = shift_q >> 1;
        shift_d[DATA_WIDTH-1]   = bit_q;
    end

    // Frame state machine with registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            edge_cnt_q <= 6'd0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            pre_q      <= 6'd8;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            mismatch_q <= 1'b0;
            samp_q     <= 2'b00;
            bit_q      <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!RX_IN) begin
                        // Detection cycle counts as edge 0 of the start bit
                        state_q    <= S_START;
                        edge_cnt_q <= 6'd1;
                        bit_cnt_q  <= '0;
                        pre_q      <= pre_d;
                        par_en_q   <= PAR_EN;
                        par_typ_q  <= PAR_TYP;
                        mismatch_q <= 1'b0;
                        busy       <= 1'b1;
                    end else begin
                        edge_cnt_q <= 6'd0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    if (edge_cnt_q == (half_d - 6'd1)) begin
                        samp_q[0] <= RX_IN;
                    end
                    if (edge_cnt_q == half_d) begin
                        samp_q[1] <= RX_IN;
                    end
                    if (edge_cnt_q == (half_d + 6'd1)) begin
                        bit_q <= maj_d;
                    end

                    if (last_edge_d) begin
                        edge_cnt_q <= 6'd0;
                        case (state_q)
                            S_START: begin
                                if (bit_q) begin
                                    // Start bit did not hold low: treat as glitch
                                    state_q <= S_IDLE;
                                    busy    <= 1'b0;
                                end else begin
                                    state_q <= S_DATA;
                                end
                            end
                            S_DATA: begin
                                shift_q <= shift_d;
                                if (bit_cnt_q == LAST_BIT) begin
                                    bit_cnt_q <= '0;
                                    state_q   <= par_en_q ? S_PARITY : S_STOP;
                                end else begin
                                    bit_cnt_q <= bit_cnt_q + BCW'(1);
                                end
                            end
                            S_PARITY: begin
                                mismatch_q <= (word_parity(shift_q) ^ par_typ_q) != bit_q;
                                state_q    <= S_STOP;
                            end
                            S_STOP: begin
                                state_q <= S_IDLE;
                                busy    <= 1'b0;
                                if (bit_q && !mismatch_q) begin
                                    data_valid <= 1'b1;
                                    P_DATA     <= shift_q;
                                end else begin
                                    par_err <= mismatch_q;
                                    stp_err <= ~bit_q;
                                end
                            end
                            default: begin
                                state_q <= S_IDLE;
                                busy    <= 1'b0;
                            end
                        endcase
                    end else begin
                        edge_cnt_q <= edge_cnt_q + 6'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- scoreboard bench for uart_rx.
// The driver serialises frames and pushes the expected outcome (flags, P_DATA
// value, cycle of the pulse) computed from the frame contents; a monitor pops
// and compares whenever the DUT raises data_valid, par_err or stp_err.
// Cycle numbering: the detection cycle is cycle 0, i.e. the cycle ending at
// the edge where the low start level is first sampled (edge D). A pulse in
// cycle N is visible just after edge D+N-1.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit         dv;
        bit         pe;
        bit         se;
        logic [7:0] pdata;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] last_good = 8'h00;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation
    always @(negedge CLK) begin
        if (!RST && (data_valid || par_err || stp_err)) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: dv=%0b pe=%0b se=%0b expected no pulse (cycle %0d)",
                         data_valid, par_err, stp_err, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("data_valid", {31'd0, data_valid}, {31'd0, mon_e.dv});
                check("par_err",    {31'd0, par_err},    {31'd0, mon_e.pe});
                check("stp_err",    {31'd0, stp_err},    {31'd0, mon_e.se});
                check("pulse_cycle", cyc, mon_e.cyc);
                check("P_DATA",     {24'd0, P_DATA},     {24'd0, mon_e.pdata});
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Serialise one frame, starting right now (just after a clock edge)
    task automatic send_frame(input int pre_in, input bit pen, input bit ptyp,
                              input logic [7:0] data, input bit flip_par, input bit stop,
                              input int spike_e, input bit scramble, input int gap);
        int   p;
        int   nbits;
        int   d;
        logic levels [0:10];
        logic par_bit;
        exp_t e;
        p = ((pre_in == 16) || (pre_in == 32)) ? pre_in : 8;
        // Even parity: the parity bit makes the total number of ones even
        par_bit = ((($countones(data) % 2) == 1) ? 1'b1 : 1'b0) ^ ptyp ^ flip_par;
        levels[0] = 1'b0;
        for (int i = 0; i < 8; i++) levels[i + 1] = data[i];
        nbits = 9;
        if (pen) begin
            levels[nbits] = par_bit;
            nbits = nbits + 1;
        end
        levels[nbits] = stop;
        nbits = nbits + 1;

        Prescale = 6'(pre_in);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        d = cyc + 1;
        e.dv = stop && !(pen && flip_par);
        e.pe = pen && flip_par;
        e.se = !stop;
        if (e.dv) last_good = data;
        e.pdata = last_good;
        e.cyc = d + p * nbits - 1;
        sb.push_back(e);

        for (int k = 0; k < nbits; k++) begin
            for (int j = 0; j < p; j++) begin
                RX_IN = levels[k] ^ ((k >= 1) && (k <= 8) && (j == spike_e));
                step();
                if (scramble && (k == 0) && (j == 0)) begin
                    Prescale = 6'($urandom_range(0, 63));
                    PAR_EN   = 1'($urandom_range(0, 1));
                    PAR_TYP  = 1'($urandom_range(0, 1));
                end
                if ((k == nbits / 2) && (j == 0)) check("busy_mid_frame", {31'd0, busy}, 32'd1);
            end
        end
        RX_IN = 1'b1;
        check("busy_after_frame", {31'd0, busy}, 32'd0);
        repeat (gap) step();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d;
        int pool [0:5];
        pool[0] = 8; pool[1] = 16; pool[2] = 32; pool[3] = 0; pool[4] = 12; pool[5] = 63;

        // Reset state
        RST = 1'b1;
        repeat (3) step();
        check("rst_P_DATA",     {24'd0, P_DATA}, 32'd0);
        check("rst_data_valid", {31'd0, data_valid}, 32'd0);
        check("rst_par_err",    {31'd0, par_err}, 32'd0);
        check("rst_stp_err",    {31'd0, stp_err}, 32'd0);
        check("rst_busy",       {31'd0, busy}, 32'd0);
        RST = 1'b0;
        repeat (3) step();

        // 0xA5, even parity, correct parity bit: data_valid in cycle 88
        send_frame(8, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, -1, 1'b0, 3);
        // Same frame, parity bit 1: par_err in cycle 88, P_DATA stays 0xA5
        send_frame(8, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, -1, 1'b0, 3);
        // Prescale 16, no parity, stop bit low: stp_err in cycle 160
        send_frame(16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, -1, 1'b0, 3);

        // Start-bit glitch: low for two cycles only
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        d = cyc + 1;
        step();
        step();
        RX_IN = 1'b1;
        while (cyc < d + 6) step();
        check("glitch_busy_cycle7", {31'd0, busy}, 32'd1);
        step();
        check("glitch_busy_cycle8", {31'd0, busy}, 32'd0);
        repeat (4) step();

        // Prescale 32 with a one-cycle spike at edge 15 of every data bit
        send_frame(32, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 15, 1'b0, 2);

        // Back-to-back frames: pulses 80 cycles apart
        send_frame(8, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, -1, 1'b0, 0);
        send_frame(8, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1, -1, 1'b0, 3);

        // Reset in the middle of the data bits, then a clean frame
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (28) step();
        RX_IN = 1'b1;
        RST   = 1'b1;
        step();
        check("midrst_P_DATA",     {24'd0, P_DATA}, 32'd0);
        check("midrst_data_valid", {31'd0, data_valid}, 32'd0);
        check("midrst_par_err",    {31'd0, par_err}, 32'd0);
        check("midrst_stp_err",    {31'd0, stp_err}, 32'd0);
        check("midrst_busy",       {31'd0, busy}, 32'd0);
        last_good = 8'h00;
        RST = 1'b0;
        repeat (2) step();
        send_frame(8, 1'b1, 1'b1, 8'h96, 1'b0, 1'b1, -1, 1'b0, 2);

        // Randomised frames, with config inputs changed while a frame is running
        for (int n = 0; n < 40; n++) begin
            int  pre;
            int  peff;
            int  sp;
            bit  pen;
            pre  = pool[$urandom_range(0, 5)];
            peff = ((pre == 16) || (pre == 32)) ? pre : 8;
            pen  = 1'($urandom_range(0, 1));
            sp   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, peff - 1)) : -1;
            send_frame(pre, pen, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0),
                       sp, 1'b1, int'($urandom_range(0, 3)));
        end

        repeat (5) step();
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
